data_path: RTL and testbench



---
 rtl/data_path_if.sv | 35 +++
 rtl/data_path.sv | 114 +++++++++++
 tb/tb_data_path.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_path_if.sv
// Bus bundle between the control unit / load path and the execution datapath.
// Status flags exist only when DATAPATH_FLAGS_EN is defined.
interface data_path_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] ir;
   logic [WIDTH-1:0] data_in;
   logic             wEn;
   logic             registerFileSelect;
   logic [WIDTH-1:0] ra_data;
   logic [WIDTH-1:0] rb_data;
   logic [WIDTH-1:0] alu_out;
`ifdef DATAPATH_FLAGS_EN
   logic             zero;
   logic             neg;
   logic             carry;
   logic             ovf;
`endif

   modport master (
      output ir, data_in, wEn, registerFileSelect,
      input  ra_data, rb_data, alu_out
`ifdef DATAPATH_FLAGS_EN
      , zero, neg, carry, ovf
`endif
   );

   modport slave (
      input  ir, data_in, wEn, registerFileSelect,
      output ra_data, rb_data, alu_out
`ifdef DATAPATH_FLAGS_EN
      , zero, neg, carry, ovf
`endif
   );
endinterface

// File: rtl/data_path.sv
// Execution datapath: 32-entry register file, operand-B mux, ALU, write-back mux.
// Optional status flags (zero/neg/carry/ovf) are built when DATAPATH_FLAGS_EN is defined.
module data_path #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   data_path_if.slave bus
);
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b1000;
   localparam logic [3:0] OP_OR   = 4'b1001;
   localparam logic [3:0] OP_XOR  = 4'b1010;
   localparam logic [3:0] OP_XNOR = 4'b1011;
   localparam logic [3:0] OP_SHL  = 4'b1100;
   localparam logic [3:0] OP_SHR  = 4'b1101;
   localparam logic [3:0] OP_SRA  = 4'b1110;

   logic             lit_sel;
   logic [3:0]       opcode;
   logic [4:0]       rc_addr;
   logic [4:0]       ra_addr;
   logic [4:0]       rb_addr;
   logic [WIDTH-1:0] lit_ext;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [4:0]       shamt;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] wb_data;
   logic             unused_ir_hi;

   logic [WIDTH-1:0] regs_q [32];
   logic [WIDTH-1:0] regs_d [32];

   assign lit_sel      = bus.ir[30];
   assign opcode       = bus.ir[29:26];
   assign rc_addr      = bus.ir[25:21];
   assign ra_addr      = bus.ir[20:16];
   assign rb_addr      = bus.ir[15:11];
   assign lit_ext      = {{(WIDTH-16){bus.ir[15]}}, bus.ir[15:0]};
   assign unused_ir_hi = |bus.ir[WIDTH-1:31];

   assign op_a  = regs_q[ra_addr];
   assign op_b  = lit_sel ? lit_ext : regs_q[rb_addr];
   assign shamt = op_b[4:0];

   always_comb begin
      alu_res = '0;
      case (opcode)
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_XNOR: alu_res = ~(op_a ^ op_b);
         OP_SHL:  alu_res = op_a << shamt;
         OP_SHR:  alu_res = op_a >> shamt;
         OP_SRA:  alu_res = WIDTH'($signed(op_a) >>> shamt);
         default: alu_res = '0;
      endcase
   end

   assign wb_data     = bus.registerFileSelect ? bus.data_in : alu_res;
   assign bus.alu_out = alu_res;
   assign bus.ra_data = regs_q[ra_addr];
   assign bus.rb_data = regs_q[rb_addr];

   // wEn gates the address compare first so undefined ir bits cannot select a register.
   always_comb begin
      for (int i = 0; i < 32; i++) begin
         regs_d[i] = regs_q[i];
         if (bus.wEn && (rc_addr == 5'(i))) begin
            regs_d[i] = wb_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

`ifdef DATAPATH_FLAGS_EN
   // Unsigned wrap of the sum marks carry-out; a >= b unsigned means no borrow.
   always_comb begin
      bus.zero  = (alu_res == '0);
      bus.neg   = alu_res[WIDTH-1];
      bus.carry = 1'b0;
      bus.ovf   = 1'b0;
      case (opcode)
         OP_ADD: begin
            bus.carry = (alu_res < op_a);
            bus.ovf   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_SUB: begin
            bus.carry = (op_a >= op_b);
            bus.ovf   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
         end
         default: begin
            bus.carry = 1'b0;
            bus.ovf   = 1'b0;
         end
      endcase
   end
`endif
endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed vectors plus a register-file model
// compared against the DUT on every falling clock edge.
module tb_data_path;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n;

   data_path_if #(.WIDTH(W)) bus ();

   data_path #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;
   bit          check_en    = 1'b0;
   logic [31:0] model [32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return 32'($signed(v));
   endfunction

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int          sh;
      logic [31:0] ones;
      sh   = int'(b[4:0]);
      ones = '1;
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd8:    return a & b;
         4'd9:    return a | b;
         4'd10:   return a ^ b;
         4'd11:   return ~(a ^ b);
         4'd12:   return a << sh;
         4'd13:   return a >> sh;
         4'd14:   return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0);
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] model_b(input logic [31:0] ir);
      return ir[30] ? sext16(ir[15:0]) : model[ir[15:11]];
   endfunction

   function automatic logic [31:0] mk_r(input logic [3:0] op, input int rc, input int ra, input int rb);
      return {2'b00, op, 5'(rc), 5'(ra), 5'(rb), 11'h0};
   endfunction

   function automatic logic [31:0] mk_i(input logic [3:0] op, input int rc, input int ra, input logic [15:0] imm);
      return {2'b01, op, 5'(rc), 5'(ra), imm};
   endfunction

   // Reference register file
   always @(negedge rst_n) begin
      for (int i = 0; i < 32; i++) model[i] <= 32'h0;
   end

   always @(posedge clk) begin
      if (rst_n === 1'b1 && bus.wEn === 1'b1) begin
         model[bus.ir[25:21]] <= bus.registerFileSelect ? bus.data_in :
            ref_alu(bus.ir[29:26], model[bus.ir[20:16]], model_b(bus.ir));
      end
   end

   // Continuous comparison against the model
   always @(negedge clk) begin
      if (check_en) begin
         logic [31:0] a, b, r;
         a = model[bus.ir[20:16]];
         b = model_b(bus.ir);
         r = ref_alu(bus.ir[29:26], a, b);
         chk("ra_data", bus.ra_data, a);
         chk("rb_data", bus.rb_data, model[bus.ir[15:11]]);
         chk("alu_out", bus.alu_out, r);
`ifdef DATAPATH_FLAGS_EN
         begin
            longint sa, sb, s;
            logic   c, v;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            c  = 1'b0;
            v  = 1'b0;
            if (bus.ir[29:26] == 4'd0) begin
               c = (33'(a) + 33'(b)) > 33'h0_FFFF_FFFF;
               s = sa + sb;
               v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end else if (bus.ir[29:26] == 4'd1) begin
               c = (a >= b);
               s = sa - sb;
               v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            chk("zero", 32'(bus.zero), 32'(r == 32'h0));
            chk("neg", 32'(bus.neg), 32'(r[31]));
            chk("carry", 32'(bus.carry), 32'(c));
            chk("ovf", 32'(bus.ovf), 32'(v));
         end
`endif
      end
   end

   task automatic op(input string name, input logic [31:0] ir, input logic wen,
                     input logic rfs, input logic [31:0] din, input logic [31:0] exp);
      @(posedge clk);
      #1;
      bus.ir                 = ir;
      bus.wEn                = wen;
      bus.registerFileSelect = rfs;
      bus.data_in            = din;
      @(negedge clk);
      $display("%-12s ir=%h wEn=%0d alu_out=%h", name, ir, wen, bus.alu_out);
      chk(name, bus.alu_out, exp);
   endtask

   task automatic load(input int rc, input logic [31:0] v);
      op($sformatf("load_r%0d", rc), mk_r(4'd0, rc, 0, 0), 1'b1, 1'b1, v,
         ref_alu(4'd0, model[0], model[0]));
   endtask

   task automatic rd(input int r, input logic [31:0] exp);
      op($sformatf("read_r%0d", r), mk_i(4'd0, 0, r, 16'h0), 1'b0, 1'b0, 32'h0, exp);
      chk($sformatf("ra_r%0d", r), bus.ra_data, exp);
   endtask

   initial begin
      rst_n                  = 1'b1;
      bus.ir                 = 32'h0;
      bus.data_in            = 32'h0;
      bus.wEn                = 1'b0;
      bus.registerFileSelect = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      rd(0, 32'h0);
      rd(4, 32'h0);
      rd(31, 32'h0);

      load(4, 32'd4);   load(7, 32'd7);   load(1, 32'd1);  load(3, 32'd3);
      load(2, 32'd2);   load(8, 32'd8);   load(9, 32'd9);  load(16, 32'h8000_0000);
      rd(4, 32'd4);     rd(7, 32'd7);     rd(9, 32'd9);    rd(16, 32'h8000_0000);

      op("add_r",  mk_r(4'b0000, 11, 4, 7),  1'b1, 1'b0, 32'h0, 32'd11);
      op("sub_r",  mk_r(4'b0001, 12, 2, 1),  1'b1, 1'b0, 32'h0, 32'd1);
      op("and_r",  mk_r(4'b1000, 13, 3, 1),  1'b1, 1'b0, 32'h0, 32'd1);
      op("or_r",   mk_r(4'b1001, 14, 3, 8),  1'b1, 1'b0, 32'h0, 32'hB);
      op("xor_r",  mk_r(4'b1010, 15, 9, 7),  1'b1, 1'b0, 32'h0, 32'hE);
      op("xnor_r", mk_r(4'b1011, 17, 9, 7),  1'b1, 1'b0, 32'h0, 32'hFFFF_FFF1);
      op("shl_r",  mk_r(4'b1100, 18, 2, 1),  1'b1, 1'b0, 32'h0, 32'd4);
      op("shr_r",  mk_r(4'b1101, 19, 2, 1),  1'b1, 1'b0, 32'h0, 32'd1);
      op("sra_r",  mk_r(4'b1110, 20, 16, 1), 1'b1, 1'b0, 32'h0, 32'hC000_0000);
      op("bad_op", mk_r(4'b0010, 21, 4, 7),  1'b1, 1'b0, 32'h0, 32'h0);
      rd(11, 32'd11);
      rd(20, 32'hC000_0000);

      op("add_i",  mk_i(4'b0000, 22, 4, 16'd1),     1'b1, 1'b0, 32'h0, 32'd5);
      op("sub_i",  mk_i(4'b0001, 23, 2, 16'd1),     1'b1, 1'b0, 32'h0, 32'd1);
      op("or_i",   mk_i(4'b1001, 24, 3, 16'd8),     1'b1, 1'b0, 32'h0, 32'hB);
      op("xor_i",  mk_i(4'b1010, 25, 9, 16'd7),     1'b1, 1'b0, 32'h0, 32'hE);
      op("sra_i",  mk_i(4'b1110, 26, 16, 16'd1),    1'b1, 1'b0, 32'h0, 32'hC000_0000);
      op("shl_i33", mk_i(4'b1100, 27, 2, 16'h0021), 1'b1, 1'b0, 32'h0, 32'd4);
      op("sext_add", mk_i(4'b0000, 28, 4, 16'hFF00), 1'b1, 1'b0, 32'h0, 32'hFFFF_FF04);
      load(31, 32'hFFFF_FFFF);
      op("sext_sub", mk_i(4'b0001, 29, 31, 16'hFF00), 1'b1, 1'b0, 32'h0, 32'h0000_00FF);
      rd(28, 32'hFFFF_FF04);
      rd(29, 32'h0000_00FF);

      // Same register read and written: old value until the edge
      op("add_self", mk_r(4'b0000, 1, 1, 1), 1'b1, 1'b0, 32'h0, 32'd2);
      chk("no_bypass", bus.ra_data, 32'd1);
      rd(1, 32'd2);

      load(0, 32'h0000_1234);
      rd(0, 32'h0000_1234);

      op("gated_add", mk_r(4'b0000, 5, 4, 7), 1'b0, 1'b0, 32'h0, 32'd11);
      rd(5, 32'h0);

      @(posedge clk);
      #1;
      check_en = 1'b0;
      bus.wEn  = 1'b0;
      bus.ir   = 'x;
      @(posedge clk);
      #1;
      bus.ir   = 32'h0;
      check_en = 1'b1;
      rd(4, 32'd4);

      // Reset asserted mid-cycle while a write is requested
      @(posedge clk);
      #1;
      bus.ir                 = mk_r(4'b0000, 5, 4, 7);
      bus.wEn                = 1'b1;
      bus.registerFileSelect = 1'b1;
      bus.data_in            = 32'h55;
      #3 rst_n = 1'b0;
      #1;
      $display("%-12s ra_data=%h", "rst_async", bus.ra_data);
      chk("rst_async_ra", bus.ra_data, 32'h0);
      chk("rst_async_rb", bus.rb_data, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      bus.wEn = 1'b0;
      rst_n   = 1'b1;
      rd(5, 32'h0);
      rd(4, 32'h0);
      rd(0, 32'h0);

      @(posedge clk);
      #1 check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
